ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
Second-generation PS/2 keyboard receiver. Runs entirely in the system clk domain: synchronises and filters ps2_clk/ps2_data, decodes 11-bit frames with start/parity/stop checking and an inactivity timeout, and folds E0/F0 prefixes into a single key-event word. Events queue in a parametrised show-ahead FIFO read by the CPU MMIO keyboard register. The scan-to-ASCII lookup remains in the wrapper above this block.

Parameters:
FILTER_COUNT, 19, consecutive stable clk cycles minus 1 required before a filtered input changes
FILTER_WIDTH, 5, counter width for FILTER_COUNT
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 100000, clk cycles without a falling edge mid-frame before the frame is aborted
TIMEOUT_WIDTH, 17, counter width for TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
ren  in  1  pop the head event (one entry per cycle high)
data  out  16  head event {6'b0, release, extended, code[7:0]}; 0 when empty
ready  out  1  FIFO non-empty
overflow  out  1  sticky: an event was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse per rejected or aborted frame

Behaviour:
- Reset: one clock, clk; reset is synchronous and active-low (rst_n). While rst_n=0 on a clk edge: FIFO empty, ready=0, data=0, overflow=0, frame_err=0, FSM=IDLE, prefix flags clear, filter outputs=1, all counters=0.
- Input path: 2-FF synchroniser per pin, then filter. The filter output takes the synchronised value once it has been stable for FILTER_COUNT+1 consecutive cycles. Shorter glitches are ignored.
- fall strobe = filtered clk prev=1 and now=0. It is high for exactly one cycle. All frame sampling happens on fall.
- FSM states and transitions:
  - IDLE: on fall, if data=0 go to DATA with bitcnt=0. If data=1, pulse frame_err and stay in IDLE.
  - DATA: on fall, shift in LSB first and increment bitcnt. After the 8th bit go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, accept the byte if stop=1 and the xor of the 8 data bits with the parity bit equals 1 (odd parity). Otherwise pulse frame_err. Return to IDLE in both cases.
- Timeout: the counter runs in any non-IDLE state and clears on every fall. When it reaches TIMEOUT_CYCLES-1: go to IDLE, discard the partial byte, clear the prefix flags, pulse frame_err.
- Prefix fold for each accepted byte:
  - E0: set extended, no push.
  - F0: set release, no push.
  - Any other byte, including E1/FA/AA: push {release, extended, byte} and clear both flags.
  - A frame error does not clear the flags; only a timeout or reset does.
- Latency: the accepted byte is registered in the cycle after the STOP fall. The push occurs in the following cycle, and ready/data reflect the entry 1 cycle after the push (3 cycles after the fall strobe).
- FIFO:
  - Show-ahead: data always shows the head entry.
  - ren with ready=1 pops. ren with ready=0 is ignored.
  - Push when full and not popping: the new event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - overflow clears on the first successful pop after it was set. If a drop occurs in that same cycle, overflow stays 1.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide, and full/empty are decided by the MSB compare. Wrap-around is natural modulo arithmetic.
- Reset mid-frame or mid-FIFO: all state is discarded immediately. The first fall after reset is treated as a start bit.

Decomposition:
- Shared package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0 and PS2_REL=8'hF0.
  - Event bit positions EV_REL=9 and EV_EXT=8.
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
- One sub-module, ps2_filter (synchroniser plus stability filter, parameters FILTER_COUNT/FILTER_WIDTH, reset value 1), instantiated twice.
- The FIFO stays inline.

Test Plan:
- Valid frame for 0x1C (parity bit 0, stop bit 1) -> 3 cycles after the stop fall: ready=1, data=16'h001C. Pulse ren -> ready=0, data=0.
- Byte sequence E0, F0, 75 -> exactly one event, data=16'h0375. A following 1C -> 16'h001C (flags cleared).
- 0x1C sent with wrong parity, then a start bit sent with data=1 -> two frame_err pulses, no push, ready stays 0.
- 9 distinct codes 0x01..0x09 with FIFO_DEPTH=8 and no reads -> overflow=1. Reads return 0x0001..0x0008 in order, the 9th event is lost, and overflow=0 after the first pop. Also cover simultaneous push and pop while full -> no overflow.
- Abort after 4 data bits and idle TIMEOUT_CYCLES -> one frame_err. Next full 0x2A frame -> data=16'h002A. Send E0, then time out mid-frame -> the extended flag is cleared.
- Low glitch of FILTER_COUNT cycles on ps2_clk mid-frame -> no bit sampled, frame decodes correctly. Assert rst_n=0 mid-frame -> FIFO empty and the next clean frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event packing for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  localparam int EV_REL = 9;
  localparam int EV_EXT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  function automatic logic [15:0] make_event(input logic rel, input logic ext,
                                             input logic [7:0] code);
    logic [15:0] ev;
    ev         = '0;
    ev[7:0]    = code;
    ev[EV_EXT] = ext;
    ev[EV_REL] = rel;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a stability filter; idles high like the PS/2 lines.
module ps2_filter #(
  parameter int FILTER_COUNT = 19,
  parameter int FILTER_WIDTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt
);

  logic                    sync1;
  logic                    sync2;
  logic [FILTER_WIDTH-1:0] cnt;

  // The output only follows after FILTER_COUNT+1 consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      filt  <= 1'b1;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == FILTER_WIDTH'(FILTER_COUNT)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + FILTER_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filtered frame decoder, E0/F0 prefix folding and a show-ahead event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_COUNT   = 19,
  parameter int FILTER_WIDTH   = 5,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data,
  output logic        ready,
  output logic        overflow,
  output logic        frame_err
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic clk_f;
  logic data_f;
  logic clk_prev;
  logic fall;

  ps2_filter #(.FILTER_COUNT(FILTER_COUNT), .FILTER_WIDTH(FILTER_WIDTH)) u_clk_filter (
    .clk(clk), .rst_n(rst_n), .pin(ps2_clk), .filt(clk_f)
  );

  ps2_filter #(.FILTER_COUNT(FILTER_COUNT), .FILTER_WIDTH(FILTER_WIDTH)) u_data_filter (
    .clk(clk), .rst_n(rst_n), .pin(ps2_data), .filt(data_f)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) clk_prev <= 1'b1;
    else        clk_prev <= clk_f;
  end

  assign fall = clk_prev & ~clk_f;

  ps2_state_t              state;
  logic [2:0]              bitcnt;
  logic [7:0]              shift_reg;
  logic                    par_bit;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  logic                    rx_valid;
  logic [7:0]              rx_byte;
  logic                    timeout;

  // Frame decoder; a fall always wins over a timeout landing on the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + TIMEOUT_WIDTH'(1);

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_f) begin
              state  <= DATA;
              bitcnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {data_f, shift_reg[7:1]};
            bitcnt    <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_f;
            state   <= STOP;
          end
          STOP: begin
            if (data_f && ((^shift_reg) ^ par_bit)) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        timeout   <= 1'b1;
      end
    end
  end

  logic        ext_flag;
  logic        rel_flag;
  logic        push;
  logic [15:0] push_word;

  // Prefix bytes only arm flags; a frame error leaves them armed, a timeout does not
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_flag  <= 1'b0;
      rel_flag  <= 1'b0;
      push      <= 1'b0;
      push_word <= '0;
    end else begin
      push <= 1'b0;
      if (timeout) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == PS2_REL) begin
          rel_flag <= 1'b1;
        end else begin
          push      <= 1'b1;
          push_word <= make_event(rel_flag, ext_flag, rx_byte);
          ext_flag  <= 1'b0;
          rel_flag  <= 1'b0;
        end
      end
    end
  end

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             do_write;
  logic             drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop      = ren & ~empty;
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign ready    = ~empty;
  assign data     = empty ? 16'h0000 : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop)     overflow <= 1'b1;
      else if (pop) overflow <= 1'b0;
    end
  end

endmodule
